// File: rtl/weight_tile_buffer_ctrl.sv
// weight_tile_buffer_ctrl
//   Weight-tile load controller for the systolic MAC array. Pops weight rows
//   from the weight FIFO into NUM_BUFS tile slots of MUL_SIZE rows each,
//   tracks how many complete tiles are buffered, and accepts tile releases
//   from the compute side.
//
// Ports
//   clk_i                      clock, rising edge
//   rst_i                      asynchronous active-high reset
//   instruction_i              start pulse, honoured only in IDLE
//   weight_fifo_valid_output   FIFO has a valid row at its output
//   next_weight_tile_i         compute releases its current tile
//   done_i                     end of operation, flush everything
//   load_weights_o             pop / shift enable (high while loading)
//   load_row_o                 row index being written
//   load_slot_o                slot being filled
//   compute_slot_o             slot compute reads (oldest full tile)
//   compute_weights_rdy_o      at least one complete tile buffered
//   compute_weights_buffered_o at least two complete tiles buffered
//   tiles_buffered_o           complete-tile count
//   underflow_o                sticky: release seen with no tile buffered
//   stall_cycles_o             starved-cycle counter (WCU_STALL_CNT_EN only)
//
// Optional feature macro: WCU_STALL_CNT_EN adds the saturating 32-bit
// stall_cycles_o counter; without it the port and logic are absent.

module weight_tile_buffer_ctrl #(
  parameter int unsigned MUL_SIZE = 8,
  parameter int unsigned NUM_BUFS = 2,
  parameter int unsigned ROW_W    = $clog2(MUL_SIZE),
  parameter int unsigned SLOT_W   = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  parameter int unsigned OCC_W    = $clog2(NUM_BUFS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instruction_i,
  input  logic              weight_fifo_valid_output,
  input  logic              next_weight_tile_i,
  input  logic              done_i,
  output logic              load_weights_o,
  output logic [ROW_W-1:0]  load_row_o,
  output logic [SLOT_W-1:0] load_slot_o,
  output logic [SLOT_W-1:0] compute_slot_o,
  output logic              compute_weights_rdy_o,
  output logic              compute_weights_buffered_o,
  output logic [OCC_W-1:0]  tiles_buffered_o,
  output logic              underflow_o
`ifdef WCU_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [SLOT_W-1:0] wr_q, wr_d;
  logic [SLOT_W-1:0] rd_q, rd_d;
  logic [OCC_W-1:0]  cnt_q, cnt_d;
  logic              unf_q, unf_d;

  logic loading;
  logic accept;
  logic complete;
  logic release_ok;

  // Slot pointer increment modulo NUM_BUFS (NUM_BUFS need not be a power of 2)
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    if (s == SLOT_W'(NUM_BUFS - 1)) begin
      return '0;
    end
    return s + SLOT_W'(1);
  endfunction

  assign loading  = (state_q == ST_LOAD);
  assign accept   = loading & weight_fifo_valid_output;
  assign complete = accept & (row_q == ROW_W'(MUL_SIZE - 1));
  // A tile finishing this cycle can be consumed straight away even at count 0
  assign release_ok = next_weight_tile_i & ((cnt_q != '0) | complete);

  // State and bookkeeping registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state, row/slot tracking and tile count
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    unf_d   = unf_q;

    if (accept) begin
      if (complete) begin
        row_d = '0;
        wr_d  = next_slot(wr_q);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end

    if (release_ok) begin
      rd_d = next_slot(rd_q);
    end else if (next_weight_tile_i) begin
      unf_d = 1'b1;
    end

    if (complete && !release_ok) begin
      cnt_d = cnt_q + OCC_W'(1);
    end else if (!complete && release_ok) begin
      cnt_d = cnt_q - OCC_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (instruction_i) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cnt_d == OCC_W'(NUM_BUFS)) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (cnt_d < OCC_W'(NUM_BUFS)) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // done_i flushes everything, including a partially loaded tile
    if (done_i) begin
      state_d = ST_IDLE;
      row_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      unf_d   = 1'b0;
    end
  end

  assign load_weights_o        = loading;
  assign load_row_o            = row_q;
  assign load_slot_o           = wr_q;
  assign compute_slot_o        = rd_q;
  assign compute_weights_rdy_o = (cnt_q != '0);
  assign tiles_buffered_o      = cnt_q;
  assign underflow_o           = unf_q;

  // With a single slot the count can never reach 2
  generate
    if (NUM_BUFS > 1) begin : g_multi_buf
      assign compute_weights_buffered_o = (cnt_q >= OCC_W'(2));
    end else begin : g_single_buf
      assign compute_weights_buffered_o = 1'b0;
    end
  endgenerate

`ifdef WCU_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        starved;

  assign starved = loading & (cnt_q == '0) & ~weight_fifo_valid_output;

  // Saturating count of cycles where compute has nothing and the FIFO is dry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (done_i) begin
      stall_q <= '0;
    end else if (starved && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_weight_tile_buffer_ctrl.sv
// Directed bench for weight_tile_buffer_ctrl (MUL_SIZE=4, NUM_BUFS=3) with a
// second NUM_BUFS=1 instance sharing the stimulus. Expected row accepts
// (slot,row) are queued as stimulus is driven and popped by a monitor when
// the DUT actually accepts a row.

module tb_weight_tile_buffer_ctrl;

  localparam int unsigned MS     = 4;
  localparam int unsigned NB     = 3;
  localparam int unsigned ROW_W  = 2;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned OCC_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic instr;
  logic valid;
  logic nxt;
  logic done;

  logic              load_weights;
  logic [ROW_W-1:0]  load_row;
  logic [SLOT_W-1:0] load_slot;
  logic [SLOT_W-1:0] compute_slot;
  logic              rdy;
  logic              buffered;
  logic [OCC_W-1:0]  tiles;
  logic              underflow;

  logic       b1_load_weights;
  logic [1:0] b1_load_row;
  logic       b1_load_slot;
  logic       b1_compute_slot;
  logic       b1_rdy;
  logic       b1_buffered;
  logic       b1_tiles;
  logic       b1_underflow;

`ifdef WCU_STALL_CNT_EN
  logic [31:0] stall;
  logic [31:0] b1_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  weight_tile_buffer_ctrl #(.MUL_SIZE(MS), .NUM_BUFS(NB)) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .instruction_i              (instr),
    .weight_fifo_valid_output   (valid),
    .next_weight_tile_i         (nxt),
    .done_i                     (done),
    .load_weights_o             (load_weights),
    .load_row_o                 (load_row),
    .load_slot_o                (load_slot),
    .compute_slot_o             (compute_slot),
    .compute_weights_rdy_o      (rdy),
    .compute_weights_buffered_o (buffered),
    .tiles_buffered_o           (tiles),
    .underflow_o                (underflow)
`ifdef WCU_STALL_CNT_EN
    ,
    .stall_cycles_o             (stall)
`endif
  );

  weight_tile_buffer_ctrl #(.MUL_SIZE(MS), .NUM_BUFS(1)) dut_b1 (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .instruction_i              (instr),
    .weight_fifo_valid_output   (valid),
    .next_weight_tile_i         (nxt),
    .done_i                     (done),
    .load_weights_o             (b1_load_weights),
    .load_row_o                 (b1_load_row),
    .load_slot_o                (b1_load_slot),
    .compute_slot_o             (b1_compute_slot),
    .compute_weights_rdy_o      (b1_rdy),
    .compute_weights_buffered_o (b1_buffered),
    .tiles_buffered_o           (b1_tiles),
    .underflow_o                (b1_underflow)
`ifdef WCU_STALL_CNT_EN
    ,
    .stall_cycles_o             (b1_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int slot, input int row);
    exp_q.push_back(8'((slot << 4) | row));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_load_weights"}, 32'(load_weights), 32'd0);
    check({tag, "_load_row"},     32'(load_row),     32'd0);
    check({tag, "_load_slot"},    32'(load_slot),    32'd0);
    check({tag, "_compute_slot"}, 32'(compute_slot), 32'd0);
    check({tag, "_rdy"},          32'(rdy),          32'd0);
    check({tag, "_buffered"},     32'(buffered),     32'd0);
    check({tag, "_tiles"},        32'(tiles),        32'd0);
    check({tag, "_underflow"},    32'(underflow),    32'd0);
`ifdef WCU_STALL_CNT_EN
    check({tag, "_stall"},        stall,             32'd0);
`endif
  endtask

  // Accept monitor: every accepted row must match the next queued expectation
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      check("nb1_buffered_never", 32'(b1_buffered), 32'd0);
      if (load_weights && valid) begin
        check("accept_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("accept_slot", 32'(load_slot), 32'(e[7:4]));
          check("accept_row",  32'(load_row),  32'(e[3:0]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; instr = 1'b0; valid = 1'b0; nxt = 1'b0; done = 1'b0;
    repeat (2) tick();
    check_idle("reset");

    // IDLE ignores a valid FIFO
    rst = 1'b0; valid = 1'b1;
    repeat (3) tick();
    check_idle("idle_valid");

    // Start and fill all three slots back to back
    instr = 1'b1; tick(); instr = 1'b0;
    check("start_load_weights", 32'(load_weights), 32'd1);
    for (int t = 0; t < 12; t++) begin
      push_row(t / 4, t % 4);
      tick();
      if (t % 4 == 3) begin
        check("fill_tiles",    32'(tiles),    32'(t / 4 + 1));
        check("fill_rdy",      32'(rdy),      32'd1);
        check("fill_buffered", 32'(buffered), 32'(t / 4 >= 1));
      end
      if (t == 3) check("nb1_tiles_one", 32'(b1_tiles), 32'd1);
    end
    check("full_load_weights", 32'(load_weights), 32'd0);
    check("full_load_slot",    32'(load_slot),    32'd0);
    check("full_load_row",     32'(load_row),     32'd0);
    check("full_compute_slot", 32'(compute_slot), 32'd0);
    repeat (2) tick();
    check("full_hold_tiles",   32'(tiles),        32'd3);
    check("full_hold_lw",      32'(load_weights), 32'd0);

    // Release from FULL reopens loading on the next cycle
    valid = 1'b0; nxt = 1'b1; tick(); nxt = 1'b0;
    check("rel_tiles",        32'(tiles),        32'd2);
    check("rel_compute_slot", 32'(compute_slot), 32'd1);
    check("rel_buffered",     32'(buffered),     32'd1);
    check("rel_load_weights", 32'(load_weights), 32'd1);

    // Completion and release in the same cycle at count 2
    valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push_row(0, r);
      tick();
    end
    push_row(0, 3); nxt = 1'b1; tick(); nxt = 1'b0; valid = 1'b0;
    check("both_tiles",        32'(tiles),        32'd2);
    check("both_load_slot",    32'(load_slot),    32'd1);
    check("both_compute_slot", 32'(compute_slot), 32'd2);
    check("both_load_row",     32'(load_row),     32'd0);
    check("both_underflow",    32'(underflow),    32'd0);

    // Drain to zero (read pointer wraps 2 -> 0), then underflow
    nxt = 1'b1; tick();
    check("drain1_tiles",        32'(tiles),        32'd1);
    check("drain1_compute_slot", 32'(compute_slot), 32'd0);
    tick();
    check("drain0_tiles",        32'(tiles),        32'd0);
    check("drain0_compute_slot", 32'(compute_slot), 32'd1);
    check("drain0_rdy",          32'(rdy),          32'd0);
    check("drain0_underflow",    32'(underflow),    32'd0);
    tick(); nxt = 1'b0;
    check("unf_tiles",        32'(tiles),        32'd0);
    check("unf_flag",         32'(underflow),    32'd1);
    check("unf_compute_slot", 32'(compute_slot), 32'd1);
    tick();
    check("unf_sticky", 32'(underflow), 32'd1);

    // Completion and release in the same cycle at count 0
    valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push_row(1, r);
      tick();
    end
    push_row(1, 3); nxt = 1'b1; tick(); nxt = 1'b0;
    check("zero_both_tiles",        32'(tiles),        32'd0);
    check("zero_both_load_slot",    32'(load_slot),    32'd2);
    check("zero_both_compute_slot", 32'(compute_slot), 32'd2);

    // Partial tile then done_i discards it and clears underflow
    push_row(2, 0); tick();
    push_row(2, 1); tick();
    valid = 1'b0;
    check("partial_row", 32'(load_row), 32'd2);
    tick();
    check("partial_row_hold", 32'(load_row), 32'd2);
    done = 1'b1; tick(); done = 1'b0;
    check_idle("done_flush");

    // Starved cycles, then a tile with FIFO valid toggling
    instr = 1'b1; tick(); instr = 1'b0;
    repeat (10) tick();
`ifdef WCU_STALL_CNT_EN
    check("stall_ten", stall, 32'd10);
`endif
    check("starve_row",   32'(load_row), 32'd0);
    check("starve_tiles", 32'(tiles),    32'd0);
    for (int i = 0; i < 8; i++) begin
      valid = (i % 2 == 1);
      if (valid) push_row(0, i / 2);
      tick();
      if (i == 6) check("toggle_tiles_pending", 32'(tiles), 32'd0);
    end
    valid = 1'b0;
    check("toggle_tiles",     32'(tiles),     32'd1);
    check("toggle_load_slot", 32'(load_slot), 32'd1);
    done = 1'b1; tick(); done = 1'b0;
    check_idle("done_after_toggle");

    // Asynchronous reset in the middle of a tile
    instr = 1'b1; tick(); instr = 1'b0;
    valid = 1'b1;
    push_row(0, 0); tick();
    push_row(0, 1); tick();
    check("pre_rst_row", 32'(load_row), 32'd2);
    #1 rst = 1'b1;
    #1 check_idle("async_rst");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_idle("post_rst_idle");
    valid = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
